// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single D-cache request port between the load issue pipe and the
// committed-store drain, with starvation and drain-mode overrides and a one-entry output slot.
module dcache_port_arbiter #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned LDQ_TAG_W    = 3,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned DRAIN_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_req_vld,
   input  logic [XLEN-1:0]       ld_req_addr,
   input  logic [LDQ_TAG_W-1:0]  ld_req_tag,
   output logic                  ld_req_rdy,
   input  logic                  st_req_vld,
   input  logic [XLEN-1:0]       st_req_addr,
   input  logic [XLEN-1:0]       st_req_data,
   input  logic [XLEN/8-1:0]     st_req_mask,
   output logic                  st_req_rdy,
   input  logic                  sdq_full,
   output logic                  dc_req_vld,
   output logic                  dc_req_we,
   output logic [XLEN-1:0]       dc_req_addr,
   output logic [XLEN-1:0]       dc_req_wdata,
   output logic [XLEN/8-1:0]     dc_req_wmask,
   output logic [LDQ_TAG_W-1:0]  dc_req_tag,
   input  logic                  dc_req_rdy,
   output logic                  drain_mode
);

   localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned DCW = $clog2(DRAIN_BURST + 1);
   localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_BURST - 1);

   typedef enum logic {NORMAL, DRAIN} mode_t;

   mode_t          state, state_nxt;
   logic [SCW-1:0] starve_cnt;
   logic [DCW-1:0] drain_cnt;
   logic           slot_free;
   logic           st_wins;

   assign slot_free = !dc_req_vld || dc_req_rdy;

   // Store takes the port when alone, or when drain mode / starvation overrides the load
   always_comb begin
      st_wins    = st_req_vld && (!ld_req_vld || state == DRAIN || starve_cnt == STARVE_MAX);
      st_req_rdy = !rst && slot_free && st_wins;
      ld_req_rdy = !rst && slot_free && ld_req_vld && !st_wins;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dc_req_vld   <= 1'b0;
         dc_req_we    <= 1'b0;
         dc_req_addr  <= '0;
         dc_req_wdata <= '0;
         dc_req_wmask <= '0;
         dc_req_tag   <= '0;
      end else if (slot_free) begin
         if (st_req_rdy) begin
            dc_req_vld   <= 1'b1;
            dc_req_we    <= 1'b1;
            dc_req_addr  <= st_req_addr;
            dc_req_wdata <= st_req_data;
            dc_req_wmask <= st_req_mask;
            dc_req_tag   <= '0;
         end else if (ld_req_rdy) begin
            dc_req_vld   <= 1'b1;
            dc_req_we    <= 1'b0;
            dc_req_addr  <= ld_req_addr;
            dc_req_wdata <= '0;
            dc_req_wmask <= '0;
            dc_req_tag   <= ld_req_tag;
         end else begin
            dc_req_vld   <= 1'b0;
         end
      end
   end

   // Counts every cycle a pending store is not granted, including busy-slot stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!st_req_vld || st_req_rdy) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= NORMAL;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drain_cnt <= '0;
      end else if (state == NORMAL) begin
         if (state_nxt == DRAIN) drain_cnt <= '0;
      end else if (st_req_rdy) begin
         drain_cnt <= drain_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         NORMAL: if (sdq_full && st_req_vld) state_nxt = DRAIN;
         DRAIN: begin
            if (!st_req_vld) state_nxt = NORMAL;
            else if (st_req_rdy && drain_cnt == DRAIN_LAST) state_nxt = NORMAL;
         end
         default: state_nxt = NORMAL;
      endcase
   end

   always_comb begin
      drain_mode = (state == DRAIN);
   end

endmodule
